// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with scoreboard bits and a clear engine.
// Optional condition codes output enabled by defining REGFILE_CC_EN.
module regfile_mp #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld_reg,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] global_data,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  input  logic             issue_vld,
  input  logic [AW-1:0]    issue_dr,
  output logic             SR1_PEND,
  output logic             SR2_PEND,
  input  logic             clr_start,
`ifdef REGFILE_CC_EN
  output logic [2:0]       cc_nzp,
`endif
  output logic             clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q;
  logic [AW-1:0]     cnt_q;
  logic              busy_q;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              wr_en;
  logic              iss_en;
  logic              byp1;
  logic              byp2;

  assign wr_en  = ld_reg && (state_q == IDLE);
  assign iss_en = issue_vld && (state_q == IDLE);
  assign byp1   = BYPASS && wr_en && (SR1 == DR);
  assign byp2   = BYPASS && wr_en && (SR2 == DR);

  assign SR1_OUT  = byp1 ? global_data : regs_q[SR1];
  assign SR2_OUT  = byp2 ? global_data : regs_q[SR2];
  // A same-cycle reissue to the register keeps it pending.
  assign SR1_PEND = (byp1 && !(iss_en && issue_dr == SR1)) ? 1'b0 : pend_q[SR1];
  assign SR2_PEND = (byp2 && !(iss_en && issue_dr == SR2)) ? 1'b0 : pend_q[SR2];
  assign clr_busy = busy_q;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (state_q == CLEAR) begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
    end else begin
      if (wr_en) begin
        regs_d[DR] = global_data;
        pend_d[DR] = 1'b0;
      end
      if (iss_en) pend_d[issue_dr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REGFILE_CC_EN
  logic [2:0] cc_q;
  logic [2:0] cc_d;

  always_comb begin
    cc_d = cc_q;
    if (wr_en)
      cc_d = {global_data[WIDTH-1],
              global_data == '0,
              !global_data[WIDTH-1] && (global_data != '0)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cc_q <= 3'b010;
    else          cc_q <= cc_d;
  end

  assign cc_nzp = cc_q;
`endif

endmodule
